// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU op encoding,
// one-hot forwarding selects, flag bit positions and default widths.
package ex_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_W_DEF  = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_MVN = 3'd3,
      OP_MOV = 3'd4,
      OP_LSL = 3'd5,
      OP_LSR = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   localparam logic [2:0] FWD_MEM = 3'b001;
   localparam logic [2:0] FWD_RF  = 3'b010;
   localparam logic [2:0] FWD_WB  = 3'b100;

   // mem_flags = {N, Z, V}
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: operands captured on start, DATA_W
// iterations, done held high until abort; low DATA_W product bits.
module ex_mul_iter #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

   logic             run_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic [DATA_W-1:0] acc_p0, mcand_p0, mplier_p0;

   // the first iteration is folded into the capture edge so done lands in
   // the DATA_W-th busy cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_p0 <= 1'b0;
         cnt_p0 <= '0;
      end else if (abort) begin
         run_p0 <= 1'b0;
         cnt_p0 <= '0;
      end else if (start) begin
         run_p0 <= 1'b1;
         cnt_p0 <= CNT_W'(1);
      end else if (run_p0 && cnt_p0 != CNT_LAST) begin
         cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         acc_p0    <= b[0] ? a : '0;
         mcand_p0  <= a << 1;
         mplier_p0 <= b >> 1;
      end else if (run_p0 && cnt_p0 != CNT_LAST) begin
         acc_p0    <= acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end

   assign done    = run_p0 && (cnt_p0 == CNT_LAST);
   assign product = acc_p0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, one-hot operand forwarding, ALU and EX/MEM
// register. Define EX_MUL_EN to build the iterative multiplier for MUL.
module ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        id_op,
   input  logic [REG_W-1:0]  id_rm,
   input  logic [REG_W-1:0]  id_rn,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_rm_val,
   input  logic [DATA_W-1:0] id_rn_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic              id_write_reg,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              flush,
   output logic [REG_W-1:0]  ex_rm,
   output logic [REG_W-1:0]  ex_rn,
   input  logic [2:0]        Fwd_A,
   input  logic [2:0]        Fwd_B,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic [DATA_W-1:0] wb_fwd_data,
   input  logic              out_ready,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_alu_out,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [REG_W-1:0]  mem_rd,
   output logic              mem_write_reg,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [2:0]        mem_flags
);
   localparam int MSB = DATA_W - 1;

   function automatic logic [DATA_W-1:0] fwd_pick(input logic [2:0] sel,
      input logic [DATA_W-1:0] rf_val, input logic [DATA_W-1:0] mem_val,
      input logic [DATA_W-1:0] wb_val);
      case (sel)
         FWD_MEM: fwd_pick = mem_val;
         FWD_WB:  fwd_pick = wb_val;
         FWD_RF:  fwd_pick = rf_val;
         default: fwd_pick = rf_val;
      endcase
   endfunction

   // returns {V, result}; MUL falls to the default and yields zero
   function automatic logic [DATA_W:0] alu_eval(input op_e op,
      input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] r;
      logic v;
      r = '0;
      v = 1'b0;
      case (op)
         OP_ADD: begin
            r = a + b;
            v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_SUB: begin
            r = a - b;
            v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_AND:  r = a & b;
         OP_MVN:  r = ~b;
         OP_MOV:  r = b;
         OP_LSL:  r = a << b[3:0];
         OP_LSR:  r = a >> b[3:0];
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   function automatic logic [2:0] flags_of(input logic [DATA_W-1:0] r, input logic v);
      logic [2:0] f;
      f = '0;
      f[FLAG_N] = r[MSB];
      f[FLAG_Z] = (r == '0);
      f[FLAG_V] = v;
      return f;
   endfunction

   logic              vld_p0, vld_p1;
   op_e               op_p0;
   logic [REG_W-1:0]  rm_p0, rn_p0, rd_p0;
   logic [DATA_W-1:0] rm_val_p0, rn_val_p0, imm_p0;
   logic              use_imm_p0, wr_p0, mrd_p0, mwr_p0;

   logic signed [DATA_W-1:0] opa, opb, opb_fwd;
   logic [DATA_W:0]   alu_out;
   logic [DATA_W-1:0] ex_result;
   logic              ex_wr, ex_done, is_mul, adv;

   assign opa     = fwd_pick(Fwd_A, rm_val_p0, mem_fwd_data, wb_fwd_data);
   assign opb_fwd = fwd_pick(Fwd_B, rn_val_p0, mem_fwd_data, wb_fwd_data);
   assign opb     = use_imm_p0 ? imm_p0 : opb_fwd;
   assign alu_out = alu_eval(op_p0, opa, opb);
   assign is_mul  = (op_p0 == OP_MUL);

`ifdef EX_MUL_EN
   typedef enum logic {S_IDLE, S_BUSY} mul_state_e;
   mul_state_e        state;
   logic              mul_start, mul_done;
   logic [DATA_W-1:0] mul_prod;

   assign mul_start = (state == S_IDLE) && vld_p0 && is_mul && !flush;

   ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .abort   (flush || ((state == S_BUSY) && adv)),
      .a       (opa),
      .b       (opb),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (mul_start) state <= S_BUSY;
            S_BUSY:  if (flush || adv) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ex_done   = vld_p0 && (!is_mul || ((state == S_BUSY) && mul_done));
   assign ex_result = is_mul ? mul_prod : alu_out[DATA_W-1:0];
   assign ex_wr     = wr_p0;
`else
   assign ex_done   = vld_p0;
   assign ex_result = alu_out[DATA_W-1:0];
   assign ex_wr     = wr_p0 && !is_mul;
`endif

   assign adv      = ex_done && !flush && (!vld_p1 || out_ready);
   assign in_ready = !vld_p0 || (ex_done && (!vld_p1 || out_ready));
   assign ex_rm    = rm_p0;
   assign ex_rn    = rn_p0;

   // ID/EX boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p0     <= 1'b0;
         op_p0      <= OP_ADD;
         rm_p0      <= '0;
         rn_p0      <= '0;
         rd_p0      <= '0;
         use_imm_p0 <= 1'b0;
         wr_p0      <= 1'b0;
         mrd_p0     <= 1'b0;
         mwr_p0     <= 1'b0;
      end else if (flush) begin
         vld_p0 <= 1'b0;
      end else if (in_valid && in_ready) begin
         vld_p0     <= 1'b1;
         op_p0      <= op_e'(id_op);
         rm_p0      <= id_rm;
         rn_p0      <= id_rn;
         rd_p0      <= id_rd;
         use_imm_p0 <= id_use_imm;
         wr_p0      <= id_write_reg;
         mrd_p0     <= id_mem_read;
         mwr_p0     <= id_mem_write;
      end else if (adv) begin
         vld_p0 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid && in_ready && !flush) begin
         rm_val_p0 <= id_rm_val;
         rn_val_p0 <= id_rn_val;
         imm_p0    <= id_imm;
      end
   end

   // EX/MEM boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1         <= 1'b0;
         mem_alu_out    <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         mem_write_reg  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_flags      <= '0;
      end else if (adv) begin
         vld_p1         <= 1'b1;
         mem_alu_out    <= ex_result;
         mem_store_data <= opb_fwd;
         mem_rd         <= rd_p0;
         mem_write_reg  <= ex_wr;
         mem_mem_read   <= mrd_p0;
         mem_mem_write  <= mwr_p0;
         mem_flags      <= flags_of(ex_result, alu_out[DATA_W]);
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign mem_valid = vld_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops and flags, stall/release,
// flush, MUL (either build) and asynchronous reset.
module tb_ex_stage;
   import ex_pkg::*;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;

   logic              clk, reset;
   logic              in_valid, in_ready;
   logic [2:0]        id_op;
   logic [REG_W-1:0]  id_rm, id_rn, id_rd;
   logic [DATA_W-1:0] id_rm_val, id_rn_val, id_imm;
   logic              id_use_imm, id_write_reg, id_mem_read, id_mem_write;
   logic              flush;
   logic [REG_W-1:0]  ex_rm, ex_rn;
   logic [2:0]        Fwd_A, Fwd_B;
   logic [DATA_W-1:0] mem_fwd_data, wb_fwd_data;
   logic              out_ready, mem_valid;
   logic [DATA_W-1:0] mem_alu_out, mem_store_data;
   logic [REG_W-1:0]  mem_rd;
   logic              mem_write_reg, mem_mem_read, mem_mem_write;
   logic [2:0]        mem_flags;

   ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .id_op(id_op), .id_rm(id_rm), .id_rn(id_rn), .id_rd(id_rd),
      .id_rm_val(id_rm_val), .id_rn_val(id_rn_val), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_write_reg(id_write_reg),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
      .ex_rm(ex_rm), .ex_rn(ex_rn), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .out_ready(out_ready), .mem_valid(mem_valid), .mem_alu_out(mem_alu_out),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd),
      .mem_write_reg(mem_write_reg), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_flags(mem_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] imm,
      input logic ui, input logic [REG_W-1:0] rd);
      in_valid     = 1'b1;
      id_op        = op;
      id_rm        = 3'd4;
      id_rn        = 3'd5;
      id_rd        = rd;
      id_rm_val    = a;
      id_rn_val    = b;
      id_imm       = imm;
      id_use_imm   = ui;
      id_write_reg = 1'b1;
      id_mem_read  = 1'b0;
      id_mem_write = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] imm,
      input logic ui, input logic [REG_W-1:0] rd);
      drive(op, a, b, imm, ui, rd);
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   logic [2:0]        t_op  [7] = '{OP_AND, OP_MVN, OP_MOV, OP_LSR, OP_ADD, OP_SUB, OP_SUB};
   logic [DATA_W-1:0] t_a   [7] = '{16'hF0F0, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
   logic [DATA_W-1:0] t_b   [7] = '{16'h0FF0, 16'hFFFF, 16'h8001, 16'h0004, 16'h0001, 16'h0001, 16'h0001};
   logic [DATA_W-1:0] t_res [7] = '{16'h00F0, 16'h0000, 16'h8001, 16'h0800, 16'h0000, 16'h7FFF, 16'hFFFF};
   logic [2:0]        t_flg [7] = '{3'b000, 3'b010, 3'b100, 3'b000, 3'b010, 3'b001, 3'b100};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; id_op = '0; id_rm = '0; id_rn = '0; id_rd = '0;
      id_rm_val = '0; id_rn_val = '0; id_imm = '0; id_use_imm = 1'b0;
      id_write_reg = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; flush = 1'b0;
      Fwd_A = FWD_RF; Fwd_B = FWD_RF; mem_fwd_data = '0; wb_fwd_data = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      chk("rst_valid", mem_valid, 0);
      chk("rst_alu", mem_alu_out, 0);
      chk("rst_flags", mem_flags, 0);
      chk("rst_ex_rm", ex_rm, 0);
      chk("rst_in_ready", in_ready, 1);

      // ADD 5 + 7 through the register-file path
      drive(OP_ADD, 16'd5, 16'd7, 16'd0, 1'b0, 3'd3);
      tick();
      in_valid = 1'b0;
      chk("add_lat_valid", mem_valid, 0);
      chk("add_ex_rm", ex_rm, 4);
      chk("add_ex_rn", ex_rn, 5);
      tick();
      chk("add_valid", mem_valid, 1);
      chk("add_out", mem_alu_out, 12);
      chk("add_flags", mem_flags, 3'b000);
      chk("add_rd", mem_rd, 3);
      chk("add_wr", mem_write_reg, 1);

      // SUB with operands from MEM and WB forwarding
      Fwd_A = FWD_MEM; Fwd_B = FWD_WB; mem_fwd_data = 16'h0003; wb_fwd_data = 16'h0003;
      run_op(OP_SUB, 16'd100, 16'd50, 16'd0, 1'b0, 3'd1);
      chk("sub_fwd_out", mem_alu_out, 0);
      chk("sub_fwd_flags", mem_flags, 3'b010);
      chk("sub_fwd_store", mem_store_data, 3);
      Fwd_A = 3'b000;
      run_op(OP_SUB, 16'd100, 16'd50, 16'd0, 1'b0, 3'd1);
      chk("sub_nonhot_out", mem_alu_out, 97);
      chk("sub_nonhot_flags", mem_flags, 3'b000);
      Fwd_A = FWD_RF; Fwd_B = FWD_RF;

      // overflow and immediate shift
      run_op(OP_ADD, 16'h7FFF, 16'h0001, 16'd0, 1'b0, 3'd2);
      chk("ovf_out", mem_alu_out, 16'h8000);
      chk("ovf_flags", mem_flags, 3'b101);
      drive(OP_LSL, 16'h0001, 16'h1234, 16'd15, 1'b1, 3'd2);
      id_mem_write = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("lsl_out", mem_alu_out, 16'h8000);
      chk("lsl_flags", mem_flags, 3'b100);
      chk("lsl_store", mem_store_data, 16'h1234);
      chk("lsl_memwr", mem_mem_write, 1);

      for (int i = 0; i < 7; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], 16'd0, 1'b0, 3'd7);
         chk($sformatf("tbl%0d_out", i), mem_alu_out, t_res[i]);
         chk($sformatf("tbl%0d_flags", i), mem_flags, t_flg[i]);
      end
      tick();

      // back-to-back stream stalled by out_ready = 0
      out_ready = 1'b0;
      drive(OP_MOV, 16'd0, 16'd0, 16'h0011, 1'b1, 3'd1);
      tick();
      chk("stall_rdy_e1", in_ready, 1);
      id_imm = 16'h0022; id_rd = 3'd2;
      tick();
      chk("stall_first_valid", mem_valid, 1);
      chk("stall_first_out", mem_alu_out, 16'h0011);
      id_imm = 16'h0033; id_rd = 3'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall%0d_out", i), mem_alu_out, 16'h0011);
         chk($sformatf("stall%0d_rd", i), mem_rd, 1);
         chk($sformatf("stall%0d_valid", i), mem_valid, 1);
         chk($sformatf("stall%0d_rdy", i), in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rel_b_out", mem_alu_out, 16'h0022);
      chk("rel_b_rd", mem_rd, 2);
      tick();
      chk("rel_c_out", mem_alu_out, 16'h0033);
      chk("rel_c_rd", mem_rd, 3);
      chk("rel_c_valid", mem_valid, 1);
      tick();
      chk("rel_drain", mem_valid, 0);

`ifdef EX_MUL_EN
      drive(OP_MUL, 16'd300, 16'd300, 16'd0, 1'b0, 3'd6);
      tick();
      in_valid = 1'b0;
      chk("mul_rdy_k", in_ready, 0);
      for (int i = 1; i < DATA_W; i++) begin
         tick();
         if (i == 1) begin
            Fwd_A = FWD_MEM;
            mem_fwd_data = 16'h0000;
         end
         chk($sformatf("mul_wait%0d_valid", i), mem_valid, 0);
         chk($sformatf("mul_wait%0d_rdy", i), in_ready, 0);
      end
      tick();
      chk("mul_last_valid", mem_valid, 0);
      chk("mul_last_rdy", in_ready, 1);
      tick();
      chk("mul_valid", mem_valid, 1);
      chk("mul_out", mem_alu_out, 16'h5F90);
      chk("mul_flags", mem_flags, 3'b000);
      chk("mul_rd", mem_rd, 6);
      Fwd_A = FWD_RF;
      tick();

      drive(OP_MUL, 16'd300, 16'd300, 16'd0, 1'b0, 3'd6);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("mul_flush_valid", mem_valid, 0);
      chk("mul_flush_rdy", in_ready, 1);
      repeat (DATA_W + 2) tick();
      chk("mul_flush_nores", mem_valid, 0);
`else
      run_op(OP_MUL, 16'd300, 16'd300, 16'd0, 1'b0, 3'd6);
      chk("mul_off_valid", mem_valid, 1);
      chk("mul_off_out", mem_alu_out, 0);
      chk("mul_off_flags", mem_flags, 3'b010);
      chk("mul_off_wr", mem_write_reg, 0);
      tick();
`endif

      // flush beats a simultaneous load and kills the op in EX
      drive(OP_ADD, 16'd1, 16'd1, 16'd0, 1'b0, 3'd2);
      tick();
      drive(OP_ADD, 16'd2, 16'd2, 16'd0, 1'b0, 3'd3);
      flush = 1'b1;
      chk("flush_rdy_pre", in_ready, 1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_kill", mem_valid, 0);
      tick();
      chk("flush_noload", mem_valid, 0);

      // asynchronous reset in the middle of a stream
      drive(OP_ADD, 16'h0010, 16'h0020, 16'd0, 1'b0, 3'd5);
      tick();
      tick();
      chk("pre_rst_valid", mem_valid, 1);
      chk("pre_rst_out", mem_alu_out, 16'h0030);
      #2 reset = 1'b0;
      #1;
      in_valid = 1'b0;
      chk("arst_valid", mem_valid, 0);
      chk("arst_out", mem_alu_out, 0);
      chk("arst_rd", mem_rd, 0);
      chk("arst_wr", mem_write_reg, 0);
      chk("arst_ex_rm", ex_rm, 0);
      chk("arst_rdy", in_ready, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      run_op(OP_ADD, 16'd5, 16'd7, 16'd0, 1'b0, 3'd3);
      chk("post_rst_valid", mem_valid, 1);
      chk("post_rst_out", mem_alu_out, 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined core. Holds the ID/EX pipeline register and applies the hazard unit's one-hot forwarding selects to both operands. Runs the ALU (plus an optional iterative multiplier) and drives the EX/MEM pipeline register. Supplies the source register numbers back to the hazard unit and consumes its `Fwd_A`/`Fwd_B`.

## Interface
- `DATA_W`, 16, datapath width
- `REG_W`, 3, register index width (8 registers)
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-low
- `in_valid` in 1 / `in_ready` out 1: decode-side handshake
- `id_op` in 3: ALU op (ADD, SUB, AND, MVN, MOV, LSL, LSR, MUL)
- `id_rm`, `id_rn`, `id_rd` in REG_W: source A, source B, destination
- `id_rm_val`, `id_rn_val` in DATA_W: register file read data
- `id_imm` in DATA_W, `id_use_imm` in 1: immediate replaces operand B
- `id_write_reg`, `id_mem_read`, `id_mem_write` in 1: control passed down
- `flush` in 1: kill the instruction in EX
- `ex_rm`, `ex_rn` out REG_W: ID/EX source indices, to hazard unit
- `Fwd_A`, `Fwd_B` in 3: one-hot select; 001 = MEM, 010 = register file, 100 = WB
- `mem_fwd_data`, `wb_fwd_data` in DATA_W: forwarded results
- `out_ready` in 1 / `mem_valid` out 1: memory-side handshake
- `mem_alu_out`, `mem_store_data` out DATA_W; `mem_rd` out REG_W
- `mem_write_reg`, `mem_mem_read`, `mem_mem_write` out 1
- `mem_flags` out 3: {N, Z, V}

## Operation
- ID/EX register loads on `in_valid & in_ready`.
  - `in_ready = !ex_valid | (ex_done & (!mem_valid | out_ready))`.
- Operand A mux, selected by `Fwd_A`: 001 → `mem_fwd_data`; 100 → `wb_fwd_data`; 010 or any non-one-hot value → latched `rm_val`.
- Operand B mux uses `Fwd_B` with the same rule. If the latched `use_imm` is 1, the immediate overrides B for the ALU.
- `mem_store_data` is always the forwarded B, never the immediate.
- Arithmetic is modulo 2^DATA_W.
  - LSL/LSR shift by `B[3:0]`, zero fill.
  - MVN = ~B; MOV = B.
- Flags:
  - Z = (result == 0); N = result[DATA_W-1].
  - V = signed overflow for ADD/SUB, 0 for every other op.
- Single-cycle ops: `ex_done = ex_valid`.
- MUL (when enabled) uses FSM IDLE → BUSY → IDLE.
  - On entry, operands are captured, so later changes on `Fwd_*` or forwarded data are ignored.
  - The multiplier runs DATA_W shift-add iterations; the result is the low DATA_W bits of the product; `ex_done` is asserted in the final cycle.
- `flush` (synchronous) clears `ex_valid` and returns the FSM to IDLE.
  - It beats a simultaneous `in_valid` load: that input is not accepted.
  - EX/MEM is unaffected because it holds an older instruction.
- EX/MEM loads on `ex_done & (!mem_valid | out_ready)`.
  - If `ex_done` is 0 and `out_ready` is 1, `mem_valid` falls to 0.
  - While it holds, all `mem_*` outputs are stable.

## Timing
- Reset values: all `mem_*` = 0, `mem_valid` = 0, `ex_rm`/`ex_rn` = 0, FSM = IDLE, `ex_valid` = 0. `in_ready` = 1 after reset.
- Reset mid-MUL aborts the multiply; no result is produced.
- Single-cycle op accepted at edge k appears on `mem_*` after edge k+1.
- Throughput: 1 op per cycle when `out_ready` = 1.
- MUL accepted at edge k: result at edge k+DATA_W+1, with `in_ready` = 0 in between.
- `Fwd_*` is sampled in the same cycle as the ALU evaluation.
- Stall: `out_ready` = 0 with `mem_valid` = 1 holds both registers and drops `in_ready` once EX is occupied.

## Configuration
- `EX_MUL_EN` defined: iterative multiplier and BUSY state are compiled in.
- `EX_MUL_EN` undefined: MUL completes in one cycle with `mem_alu_out` = 0, flags {0,1,0}, and `mem_write_reg` forced to 0. No BUSY state exists.

## Structure
- Package `ex_pkg` holds:
  - the op enum (3 bit)
  - the one-hot forwarding constants `FWD_MEM` = 001, `FWD_RF` = 010, `FWD_WB` = 100
  - the flag bit positions
  - the default widths
- Sub-module `ex_mul_iter`: start/done shift-add multiplier, DATA_W cycles. It is instantiated only under `EX_MUL_EN`.

## Test plan
- ADD, rm_val = 5, rn_val = 7, `Fwd_A` = `Fwd_B` = 010 → `mem_alu_out` = 12, flags {0,0,0}, `mem_valid` one cycle after acceptance.
- SUB with `Fwd_A` = 001 (`mem_fwd_data` = 0x0003) and `Fwd_B` = 100 (`wb_fwd_data` = 0x0003) → result 0, Z = 1. Then `Fwd_A` = 000 → falls back to rm_val.
- ADD 0x7FFF + 0x0001 → 0x8000, N = 1, V = 1. LSL 0x0001 by imm 15 → 0x8000, V = 0.
- `out_ready` held 0 for 3 cycles with a back-to-back stream:
  - `mem_*` frozen and `in_ready` = 0;
  - on release, results appear in order with no loss or duplication.
- `EX_MUL_EN`: MUL 300 × 300 → 0x5F90 after DATA_W+1 cycles.
  - `flush` in cycle 5 aborts it: no `mem_valid`, and `in_ready` returns to 1.
- `reset` asserted mid-stream → all outputs 0 immediately (asynchronous). The first op after release completes normally.
